// File: rtl/router_pkt_fifo_if.sv
// Handshake/data bundle for one router output channel FIFO.
//   slave  : the FIFO side (takes wr_en/rd_en/lfd_state/din, returns read data and status)
//   master : the user side (write FSM plus read-side consumer)
// Signals: wr_en, rd_en, lfd_state, din -> FIFO; dout, dout_valid, rd_sof, rd_eop,
//          full, empty, almost_full, count, ovf, udf <- FIFO.
interface router_pkt_fifo_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
);
   logic              wr_en;
   logic              rd_en;
   logic              lfd_state;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              rd_sof;
   logic              rd_eop;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic [ADDR_W:0]   count;
   logic              ovf;
   logic              udf;

   modport master (
      output wr_en, rd_en, lfd_state, din,
      input  dout, dout_valid, rd_sof, rd_eop, full, empty, almost_full, count, ovf, udf
   );

   modport slave (
      input  wr_en, rd_en, lfd_state, din,
      output dout, dout_valid, rd_sof, rd_eop, full, empty, almost_full, count, ovf, udf
   );
endinterface

// File: rtl/router_pkt_fifo.sv
// Packet-aware FIFO for one router output channel. Each stored word carries a header
// tag (the registered lfd_state). On read, a header's length field loads a remaining-word
// counter so the block can flag start-of-packet and end-of-packet (the parity word).
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset
//   soft_rst : synchronous active-high flush (channel timeout), below rst in priority
//   bus      : router_pkt_fifo_if.slave -- write/read requests, data, status flags
module router_pkt_fifo #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned LEN_LSB  = 2,
   parameter int unsigned AF_LEVEL = 14
) (
   input logic             clk,
   input logic             rst,
   input logic             soft_rst,
   router_pkt_fifo_if.slave bus
);
   localparam int unsigned Depth = 2 ** ADDR_W;
   localparam int unsigned LenW  = DATA_W - LEN_LSB;
   localparam int unsigned RemW  = LenW + 1;
   localparam logic [ADDR_W:0] AfLevel = (ADDR_W + 1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] PtrOne  = (ADDR_W + 1)'(1);

   logic [DATA_W:0]   mem [Depth];
   logic [ADDR_W:0]   wr_ptr_q, rd_ptr_q, count_q;
   logic [RemW-1:0]   rem_q;
   logic              lfd_q;
   logic [DATA_W-1:0] dout_q;
   logic              dout_valid_q, rd_sof_q, rd_eop_q, ovf_q, udf_q;

   logic              full_w, empty_w, wr_acc, rd_acc;
   logic [DATA_W:0]   rd_word;

   assign empty_w = (wr_ptr_q == rd_ptr_q);
   assign full_w  = (wr_ptr_q == {~rd_ptr_q[ADDR_W], rd_ptr_q[ADDR_W-1:0]});

   // Acceptance is gated by both resets so the memory write below stays consistent
   // with the pointer update.
   assign wr_acc  = rst && !soft_rst && bus.wr_en && !full_w;
   assign rd_acc  = rst && !soft_rst && bus.rd_en && !empty_w;
   assign rd_word = mem[rd_ptr_q[ADDR_W-1:0]];

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr_q[ADDR_W-1:0]] <= {lfd_q, bus.din};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         rem_q        <= '0;
         lfd_q        <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         rd_sof_q     <= 1'b0;
         rd_eop_q     <= 1'b0;
         ovf_q        <= 1'b0;
         udf_q        <= 1'b0;
      end else begin
         lfd_q <= bus.lfd_state;
         if (soft_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rem_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            rd_sof_q     <= 1'b0;
            rd_eop_q     <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
         end else begin
            if (bus.wr_en && full_w) ovf_q <= 1'b1;
            if (bus.rd_en && empty_w) udf_q <= 1'b1;
            if (wr_acc) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (rd_acc) rd_ptr_q <= rd_ptr_q + PtrOne;
            case ({wr_acc, rd_acc})
               2'b10:   count_q <= count_q + PtrOne;
               2'b01:   count_q <= count_q - PtrOne;
               default: count_q <= count_q;
            endcase
            dout_valid_q <= rd_acc;
            rd_sof_q     <= 1'b0;
            rd_eop_q     <= 1'b0;
            if (rd_acc) begin
               dout_q <= rd_word[DATA_W-1:0];
               if (rd_word[DATA_W]) begin
                  // Header: payload length plus the trailing parity word. A header
                  // mid-packet simply restarts the count.
                  rem_q    <= RemW'(rd_word[DATA_W-1:LEN_LSB]) + RemW'(1);
                  rd_sof_q <= 1'b1;
               end else if (rem_q != '0) begin
                  rem_q    <= rem_q - RemW'(1);
                  rd_eop_q <= (rem_q == RemW'(1));
               end
               // Untagged word with rem_q == 0 is a stray: output it, no markers.
            end
         end
      end
   end

   assign bus.dout        = dout_q;
   assign bus.dout_valid  = dout_valid_q;
   assign bus.rd_sof      = rd_sof_q;
   assign bus.rd_eop      = rd_eop_q;
   assign bus.full        = full_w;
   assign bus.empty       = empty_w;
   assign bus.almost_full = (count_q >= AfLevel);
   assign bus.count       = count_q;
   assign bus.ovf         = ovf_q;
   assign bus.udf         = udf_q;
endmodule

// File: tb/tb_router_pkt_fifo.sv
// Self-checking bench for router_pkt_fifo: a queue-level scoreboard holds {tag, data}
// for every accepted write; each clock step compares all outputs against the model.
module tb_router_pkt_fifo;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned ADDR_W   = 4;
   localparam int unsigned LEN_LSB  = 2;
   localparam int unsigned AF_LEVEL = 14;
   localparam int          DEPTH    = 16;

   logic clk = 1'b0;
   logic rst;
   logic soft_rst;

   router_pkt_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   router_pkt_fifo #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .LEN_LSB (LEN_LSB),
      .AF_LEVEL(AF_LEVEL)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .soft_rst(soft_rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [DATA_W:0]   sb_q [$];
   int                m_count = 0;
   int                m_rem   = 0;
   logic              m_lfd   = 1'b0;
   logic [DATA_W-1:0] m_dout  = '0;
   logic              m_valid = 1'b0;
   logic              m_ovf   = 1'b0;
   logic              m_udf   = 1'b0;
   logic              last_w, last_r;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: update the model from the current inputs, clock, then compare.
   task automatic step();
      logic w_acc, r_acc, e_sof, e_eop;
      logic [DATA_W:0] ent;
      e_sof = 1'b0;
      e_eop = 1'b0;
      w_acc = rst && !soft_rst && bus.wr_en && (m_count != DEPTH);
      r_acc = rst && !soft_rst && bus.rd_en && (m_count != 0);
      if (!rst || soft_rst) begin
         sb_q.delete();
         m_count = 0;
         m_rem   = 0;
         m_dout  = '0;
         m_ovf   = 1'b0;
         m_udf   = 1'b0;
      end else begin
         if (bus.wr_en && m_count == DEPTH) m_ovf = 1'b1;
         if (bus.rd_en && m_count == 0) m_udf = 1'b1;
         if (r_acc) begin
            ent    = sb_q.pop_front();
            m_dout = ent[DATA_W-1:0];
            if (ent[DATA_W]) begin
               m_rem = int'(ent[DATA_W-1:LEN_LSB]) + 1;
               e_sof = 1'b1;
            end else if (m_rem != 0) begin
               e_eop = (m_rem == 1);
               m_rem--;
            end
         end
         if (w_acc) sb_q.push_back({m_lfd, bus.din});
         m_count = sb_q.size();
      end
      m_lfd   = rst ? bus.lfd_state : 1'b0;
      m_valid = r_acc;
      last_w  = w_acc;
      last_r  = r_acc;
      @(posedge clk);
      #1;
      chk("dout", 32'(bus.dout), 32'(m_dout));
      chk("dout_valid", 32'(bus.dout_valid), 32'(m_valid));
      chk("rd_sof", 32'(bus.rd_sof), 32'(e_sof));
      chk("rd_eop", 32'(bus.rd_eop), 32'(e_eop));
      chk("count", 32'(bus.count), 32'(m_count));
      chk("full", 32'(bus.full), 32'(m_count == DEPTH));
      chk("empty", 32'(bus.empty), 32'(m_count == 0));
      chk("almost_full", 32'(bus.almost_full), 32'(m_count >= AF_LEVEL));
      chk("ovf", 32'(bus.ovf), 32'(m_ovf));
      chk("udf", 32'(bus.udf), 32'(m_udf));
   endtask

   task automatic idle();
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      soft_rst  = 1'b0;
   endtask

   task automatic wr(input logic [DATA_W-1:0] d);
      bus.wr_en = 1'b1;
      bus.din   = d;
      step();
      bus.wr_en = 1'b0;
   endtask

   task automatic rd(input int n);
      bus.rd_en = 1'b1;
      for (int i = 0; i < n; i++) step();
      bus.rd_en = 1'b0;
   endtask

   task automatic flush();
      soft_rst = 1'b1;
      step();
      soft_rst = 1'b0;
   endtask

   initial begin
      rst           = 1'b0;
      soft_rst      = 1'b0;
      bus.wr_en     = 1'b0;
      bus.rd_en     = 1'b0;
      bus.lfd_state = 1'b0;
      bus.din       = '0;

      // Reset
      step();
      step();
      rst = 1'b1;
      step();
      chk("reset_dout", 32'(bus.dout), 32'h0);
      chk("reset_empty", 32'(bus.empty), 32'h1);

      // Packet round trip: header 0x0C (len 3) + 3 payload + parity
      bus.lfd_state = 1'b1;
      step();
      bus.lfd_state = 1'b0;
      wr(8'h0C);
      wr(8'h11);
      wr(8'h22);
      wr(8'h33);
      wr(8'h5A);
      rd(5);
      chk("rt_count_end", 32'(bus.count), 32'h0);

      // Fill, overflow, drain, underflow
      for (int i = 0; i < DEPTH; i++) wr(8'(8'h80 + i));
      chk("fill_full", 32'(bus.full), 32'h1);
      wr(8'hEE);
      chk("ovf_set", 32'(bus.ovf), 32'h1);
      rd(DEPTH);
      chk("drain_empty", 32'(bus.empty), 32'h1);
      rd(1);
      chk("udf_set", 32'(bus.udf), 32'h1);
      chk("udf_no_valid", 32'(bus.dout_valid), 32'h0);

      // Concurrent access at count 5, at empty, at full
      flush();
      for (int i = 0; i < 5; i++) wr(8'(8'h20 + i));
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      bus.din   = 8'h77;
      step();
      chk("conc_mid_count", 32'(bus.count), 32'd5);
      chk("conc_mid_dout", 32'(bus.dout), 32'h20);
      idle();
      rd(5);
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      bus.din   = 8'h66;
      step();
      chk("conc_empty_count", 32'(bus.count), 32'd1);
      idle();
      flush();
      for (int i = 0; i < DEPTH; i++) wr(8'(8'hC0 + i));
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      bus.din   = 8'h55;
      step();
      chk("conc_full_count", 32'(bus.count), 32'd15);
      idle();

      // Wrap-around stream of 40 words with random gaps
      flush();
      begin
         int wn = 0;
         int rn = 0;
         for (int c = 0; c < 800 && (wn < 40 || m_count != 0); c++) begin
            bus.wr_en = (wn < 40) && ($urandom_range(0, 2) != 0);
            bus.rd_en = ($urandom_range(0, 1) != 0);
            bus.din   = 8'(wn + 8'h40);
            step();
            if (last_w) wn++;
            if (last_r) rn++;
         end
         idle();
         chk("wrap_written", 32'(wn), 32'd40);
         chk("wrap_read", 32'(rn), 32'd40);
      end

      // Flush mid-packet: header len 10 (0x28), read header, 7 left, then soft_rst+write
      bus.lfd_state = 1'b1;
      step();
      bus.lfd_state = 1'b0;
      wr(8'h28);
      for (int i = 0; i < 7; i++) wr(8'(8'hA0 + i));
      rd(1);
      chk("pre_flush_count", 32'(bus.count), 32'd7);
      soft_rst  = 1'b1;
      bus.wr_en = 1'b1;
      bus.din   = 8'hBB;
      step();
      idle();
      chk("flush_count", 32'(bus.count), 32'd0);
      chk("flush_dout", 32'(bus.dout), 32'h0);
      bus.lfd_state = 1'b1;
      step();
      bus.lfd_state = 1'b0;
      wr(8'h04);
      wr(8'hD1);
      wr(8'hD2);
      rd(3);
      chk("post_flush_eop", 32'(bus.rd_eop), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
